// File: rtl/alt_vipitc130_common_pkg.sv
// ---------------------------------------------------------------------------
// alt_vipitc130_common_pkg
// Shared definitions for the ITC input-side frame trigger logic:
//   - Avalon-ST video packet type codes (low nibble of the sop beat)
//   - packet tracker state encoding
//   - status counter widths
// ---------------------------------------------------------------------------
package alt_vipitc130_common_pkg;

   localparam logic [3:0] PKT_VIDEO = 4'h0;
   localparam logic [3:0] PKT_CTRL  = 4'hF;

   localparam int FRAME_COUNT_W  = 16;
   localparam int MISSED_COUNT_W = 8;

   typedef enum logic [1:0] {
      WAIT_SOP = 2'd0,
      VIDEO    = 2'd1,
      CTRL     = 2'd2,
      OTHER    = 2'd3
   } state_e;

endpackage

// File: rtl/alt_vipitc130_common_pkt_tracker.sv
// ---------------------------------------------------------------------------
// alt_vipitc130_common_pkt_tracker
// Follows the snooped Avalon-ST packet structure, counts pixel beats of
// video packets and flags the beat whose index matches the offset latched
// on that packet's sop beat.
//
// Ports:
//   input_clock        clock, posedge
//   input_rst          asynchronous reset, active-high
//   enable_i           allows the fire strobe; tracking always continues
//   beat_i             valid & ready for this cycle
//   sop_i / eop_i      packet delimiters of the current beat
//   pkt_type_i         data[3:0], meaningful on the sop beat
//   trigger_offset_i   0-based pixel index to fire on, latched on video sop
//   fire_o             combinational strobe on the firing beat
//   short_frame_o      combinational strobe on an eop beat that ends a video
//                      packet before the offset was reached
// ---------------------------------------------------------------------------
module alt_vipitc130_common_pkt_tracker
   import alt_vipitc130_common_pkg::*;
#(
   parameter int OFFSET_WIDTH = 16
) (
   input  logic                    input_clock,
   input  logic                    input_rst,
   input  logic                    enable_i,
   input  logic                    beat_i,
   input  logic                    sop_i,
   input  logic                    eop_i,
   input  logic [3:0]              pkt_type_i,
   input  logic [OFFSET_WIDTH-1:0] trigger_offset_i,
   output logic                    fire_o,
   output logic                    short_frame_o
);

   state_e                  state_q,  state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q,    cnt_d;
   logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
   logic                    armed_q,  armed_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge input_clock or posedge input_rst) begin
      if (input_rst) begin
         state_q  <= WAIT_SOP;
         cnt_q    <= '0;
         offset_q <= '0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         offset_q <= offset_d;
         armed_q  <= armed_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no
   // branch can leave a value unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      offset_d      = offset_q;
      armed_d       = armed_q;
      fire_o        = 1'b0;
      short_frame_o = 1'b0;

      if (beat_i) begin
         if (sop_i) begin
            // A sop beat always starts a fresh packet, abandoning whatever
            // was in flight without reporting it as short.
            case (pkt_type_i)
               PKT_VIDEO: begin
                  cnt_d    = '0;
                  offset_d = trigger_offset_i;
                  armed_d  = 1'b1;
                  state_d  = VIDEO;
                  // A video packet with no pixel beats never reaches its offset.
                  if (eop_i) begin
                     armed_d       = 1'b0;
                     short_frame_o = 1'b1;
                  end
               end
               PKT_CTRL: state_d = CTRL;
               default:  state_d = OTHER;
            endcase
            if (eop_i) state_d = WAIT_SOP;
         end else begin
            case (state_q)
               VIDEO: begin
                  // Arming is consumed even when enable is low, so a
                  // disabled frame neither fires late nor reports short.
                  if (armed_q && (cnt_q == offset_q)) begin
                     fire_o  = enable_i;
                     armed_d = 1'b0;
                  end
                  if (cnt_q != '1) cnt_d = cnt_q + OFFSET_WIDTH'(1);
                  if (eop_i) begin
                     state_d       = WAIT_SOP;
                     short_frame_o = armed_d;
                  end
               end
               CTRL, OTHER: begin
                  if (eop_i) state_d = WAIT_SOP;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/alt_vipitc130_common_frame_trigger.sv
// ---------------------------------------------------------------------------
// alt_vipitc130_common_frame_trigger
// Input-clock-domain frame-start trigger. Snoops the video stream entering
// the ITC and raises a level trigger at a programmable pixel-beat offset in
// each video packet; the trigger is held until ack_in.
//
// Ports:
//   input_clock, input_rst   clock (posedge) and async active-high reset
//   enable                   allow trigger firing
//   vid_valid/ready/sop/eop  snooped Avalon-ST control
//   vid_data                 snooped data; [3:0] is the packet type on sop
//   trigger_offset           pixel-beat index to fire on
//   ack_in                   trigger consumed
//   trigger_out              level trigger request (registered)
//   frame_count              fired triggers, wrapping (registered)
//   missed_count             fires while a request was pending, saturating
//   short_frame              one-cycle pulse after a short video packet
//
// Build option: define ALT_VIPITC130_FRAME_TRIGGER_STATUS_EN to implement
// frame_count, missed_count and short_frame; otherwise they are tied to 0.
// ---------------------------------------------------------------------------
module alt_vipitc130_common_frame_trigger
   import alt_vipitc130_common_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int OFFSET_WIDTH = 16
) (
   input  logic                      input_clock,
   input  logic                      input_rst,
   input  logic                      enable,
   input  logic                      vid_valid,
   input  logic                      vid_ready,
   input  logic                      vid_sop,
   input  logic                      vid_eop,
   input  logic [DATA_WIDTH-1:0]     vid_data,
   input  logic [OFFSET_WIDTH-1:0]   trigger_offset,
   input  logic                      ack_in,
   output logic                      trigger_out,
   output logic [FRAME_COUNT_W-1:0]  frame_count,
   output logic [MISSED_COUNT_W-1:0] missed_count,
   output logic                      short_frame
);

   logic fire;
   logic short_strobe;
   logic trigger_q, trigger_d;

   // Only the packet-type nibble of the data is of interest here.
   logic [DATA_WIDTH-5:0] unused_vid_data_hi;
   assign unused_vid_data_hi = vid_data[DATA_WIDTH-1:4];

   alt_vipitc130_common_pkt_tracker #(
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_pkt_tracker (
      .input_clock      (input_clock),
      .input_rst        (input_rst),
      .enable_i         (enable),
      .beat_i           (vid_valid & vid_ready),
      .sop_i            (vid_sop),
      .eop_i            (vid_eop),
      .pkt_type_i       (vid_data[3:0]),
      .trigger_offset_i (trigger_offset),
      .fire_o           (fire),
      .short_frame_o    (short_strobe)
   );

   // Fire wins over ack: the ack cycle is taken downstream as the re-arm.
   always_comb begin
      trigger_d = trigger_q;
      if (fire)                 trigger_d = 1'b1;
      else if (ack_in)          trigger_d = 1'b0;
   end

   always_ff @(posedge input_clock or posedge input_rst) begin
      if (input_rst) trigger_q <= 1'b0;
      else           trigger_q <= trigger_d;
   end

   assign trigger_out = trigger_q;

`ifdef ALT_VIPITC130_FRAME_TRIGGER_STATUS_EN
   logic [FRAME_COUNT_W-1:0]  frame_count_q,  frame_count_d;
   logic [MISSED_COUNT_W-1:0] missed_count_q, missed_count_d;
   logic                      short_frame_q;

   always_comb begin
      frame_count_d  = frame_count_q;
      missed_count_d = missed_count_q;
      if (fire) begin
         frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
         // A fire overlapping the ack is a re-arm, not a miss.
         if (trigger_q && !ack_in && (missed_count_q != '1))
            missed_count_d = missed_count_q + MISSED_COUNT_W'(1);
      end
   end

   always_ff @(posedge input_clock or posedge input_rst) begin
      if (input_rst) begin
         frame_count_q  <= '0;
         missed_count_q <= '0;
         short_frame_q  <= 1'b0;
      end else begin
         frame_count_q  <= frame_count_d;
         missed_count_q <= missed_count_d;
         short_frame_q  <= short_strobe;
      end
   end

   assign frame_count  = frame_count_q;
   assign missed_count = missed_count_q;
   assign short_frame  = short_frame_q;
`else
   logic unused_short_strobe;
   assign unused_short_strobe = short_strobe;

   assign frame_count  = '0;
   assign missed_count = '0;
   assign short_frame  = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc130_common_frame_trigger.sv
// ---------------------------------------------------------------------------
// tb_alt_vipitc130_common_frame_trigger
// Directed bench for the ITC frame trigger. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point, so each cyc() call
// shows the registered result of the beat it presented.
// Status outputs are expected to be 0 unless
// ALT_VIPITC130_FRAME_TRIGGER_STATUS_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_alt_vipitc130_common_frame_trigger;

`ifdef ALT_VIPITC130_FRAME_TRIGGER_STATUS_EN
   localparam bit STATUS = 1'b1;
`else
   localparam bit STATUS = 1'b0;
`endif

   logic        input_clock = 1'b0;
   logic        input_rst   = 1'b0;
   logic        enable      = 1'b1;
   logic        vid_valid   = 1'b0;
   logic        vid_ready   = 1'b0;
   logic        vid_sop     = 1'b0;
   logic        vid_eop     = 1'b0;
   logic [23:0] vid_data    = '0;
   logic [15:0] trigger_offset = '0;
   logic        ack_in      = 1'b0;
   logic        trigger_out;
   logic [15:0] frame_count;
   logic [7:0]  missed_count;
   logic        short_frame;

   int compared   = 0;
   int mismatched = 0;
   int exp_frames = 0;
   int exp_missed = 0;

   always #5 input_clock = ~input_clock;

   alt_vipitc130_common_frame_trigger #(
      .DATA_WIDTH   (24),
      .OFFSET_WIDTH (16)
   ) dut (
      .input_clock    (input_clock),
      .input_rst      (input_rst),
      .enable         (enable),
      .vid_valid      (vid_valid),
      .vid_ready      (vid_ready),
      .vid_sop        (vid_sop),
      .vid_eop        (vid_eop),
      .vid_data       (vid_data),
      .trigger_offset (trigger_offset),
      .ack_in         (ack_in),
      .trigger_out    (trigger_out),
      .frame_count    (frame_count),
      .missed_count   (missed_count),
      .short_frame    (short_frame)
   );

   function automatic logic [15:0] fc_exp();
      return STATUS ? 16'(exp_frames) : 16'd0;
   endfunction

   function automatic logic [7:0] mc_exp();
      return STATUS ? 8'(exp_missed) : 8'd0;
   endfunction

   // One clock cycle of stimulus; returns 1 ns after the edge.
   task automatic cyc(input logic v, input logic r, input logic s, input logic e,
                      input logic [3:0] typ, input logic ack);
      vid_valid = v; vid_ready = r; vid_sop = s; vid_eop = e;
      vid_data  = {20'hA5C3E, typ};
      ack_in    = ack;
      @(posedge input_clock); #1;
      vid_valid = 1'b0; vid_ready = 1'b0; vid_sop = 1'b0; vid_eop = 1'b0;
      ack_in    = 1'b0;
   endtask

   task automatic sop(input logic [3:0] typ, input logic e, input logic [15:0] off);
      trigger_offset = off;
      cyc(1'b1, 1'b1, 1'b1, e, typ, 1'b0);
      // Offset must have been latched; a changing input must not matter.
      trigger_offset = 16'h7777;
   endtask

   task automatic pix(input logic e, input logic ack);
      cyc(1'b1, 1'b1, 1'b0, e, 4'h5, ack);
   endtask

   task automatic gap();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic ack_only();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
   endtask

   task automatic test_reset();
      input_rst = 1'b1;
      repeat (2) @(posedge input_clock);
      #1;
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL reset_trigger got %0b want 0", trigger_out); end
      compared++; if (frame_count !== 16'd0) begin mismatched++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
      compared++; if (missed_count !== 8'd0) begin mismatched++; $display("FAIL reset_missed_count got %0d want 0", missed_count); end
      compared++; if (short_frame !== 1'b0) begin mismatched++; $display("FAIL reset_short_frame got %0b want 0", short_frame); end
      input_rst = 1'b0;
      @(posedge input_clock); #1;
   endtask

   task automatic test_video_offset();
      sop(4'h0, 1'b0, 16'd3);
      pix(1'b0, 1'b0);          // pixel 0
      gap();
      pix(1'b0, 1'b0);          // pixel 1
      pix(1'b0, 1'b0);          // pixel 2
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL early_trigger got %0b want 0", trigger_out); end
      gap();
      pix(1'b0, 1'b0);          // pixel 3: fires
      exp_frames++;
      compared++; if (trigger_out !== 1'b1) begin mismatched++; $display("FAIL offset3_trigger got %0b want 1", trigger_out); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL offset3_frame_count got %0d want %0d", frame_count, fc_exp()); end
      for (int i = 4; i < 9; i++) begin
         pix(1'b0, 1'b0);
         if (i == 6) gap();
      end
      pix(1'b1, 1'b0);          // pixel 9 with eop
      compared++; if (short_frame !== 1'b0) begin mismatched++; $display("FAIL full_frame_short got %0b want 0", short_frame); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL single_fire_count got %0d want %0d", frame_count, fc_exp()); end
      ack_only();
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL ack_clear got %0b want 0", trigger_out); end
   endtask

   task automatic test_ctrl_then_video();
      sop(4'hF, 1'b0, 16'd0);
      pix(1'b0, 1'b0);
      pix(1'b0, 1'b0);
      pix(1'b1, 1'b0);
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL ctrl_no_fire got %0b want 0", trigger_out); end
      sop(4'h0, 1'b0, 16'd0);
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL sop_not_pixel got %0b want 0", trigger_out); end
      pix(1'b0, 1'b0);          // pixel 0 fires
      exp_frames++;
      compared++; if (trigger_out !== 1'b1) begin mismatched++; $display("FAIL offset0_trigger got %0b want 1", trigger_out); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL offset0_frame_count got %0d want %0d", frame_count, fc_exp()); end
      pix(1'b1, 1'b0);
   endtask

   task automatic test_missed_and_same_cycle_ack();
      // trigger_out is still pending from the previous test
      sop(4'h0, 1'b0, 16'd1);
      pix(1'b0, 1'b0);
      pix(1'b0, 1'b0);          // fires while pending, no ack
      exp_frames++; exp_missed++;
      compared++; if (missed_count !== mc_exp()) begin mismatched++; $display("FAIL missed_once got %0d want %0d", missed_count, mc_exp()); end
      compared++; if (trigger_out !== 1'b1) begin mismatched++; $display("FAIL missed_holds got %0b want 1", trigger_out); end
      pix(1'b1, 1'b0);
      sop(4'h0, 1'b0, 16'd0);
      pix(1'b0, 1'b1);          // fire together with ack
      exp_frames++;
      compared++; if (trigger_out !== 1'b1) begin mismatched++; $display("FAIL fire_ack_holds got %0b want 1", trigger_out); end
      compared++; if (missed_count !== mc_exp()) begin mismatched++; $display("FAIL fire_ack_no_miss got %0d want %0d", missed_count, mc_exp()); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL fire_ack_count got %0d want %0d", frame_count, fc_exp()); end
      pix(1'b1, 1'b0);
      ack_only();
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL ack_after_fire got %0b want 0", trigger_out); end
      ack_only();               // ack while low is ignored
      compared++; if (trigger_out !== 1'b0 || missed_count !== mc_exp()) begin mismatched++; $display("FAIL idle_ack got trig=%0b miss=%0d want trig=0 miss=%0d", trigger_out, missed_count, mc_exp()); end
   endtask

   task automatic test_short_frame();
      sop(4'h0, 1'b0, 16'd5);
      pix(1'b0, 1'b0);
      pix(1'b1, 1'b0);          // eop on pixel 1
      compared++; if (short_frame !== STATUS) begin mismatched++; $display("FAIL short_pulse got %0b want %0b", short_frame, STATUS); end
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL short_no_trigger got %0b want 0", trigger_out); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL short_count got %0d want %0d", frame_count, fc_exp()); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      compared++; if (short_frame !== 1'b0) begin mismatched++; $display("FAIL short_one_cycle got %0b want 0", short_frame); end
      sop(4'h0, 1'b1, 16'd0);   // video sop+eop: no pixel beats
      compared++; if (short_frame !== STATUS) begin mismatched++; $display("FAIL empty_video_short got %0b want %0b", short_frame, STATUS); end
      sop(4'h3, 1'b1, 16'd0);   // non-video single beat
      compared++; if (short_frame !== 1'b0) begin mismatched++; $display("FAIL other_single_short got %0b want 0", short_frame); end
   endtask

   task automatic test_sop_abandon_and_reset();
      sop(4'h0, 1'b0, 16'd2);
      pix(1'b0, 1'b0);          // old packet pixel 0
      sop(4'h0, 1'b0, 16'd1);   // abandons old packet
      compared++; if (short_frame !== 1'b0) begin mismatched++; $display("FAIL abandon_no_short got %0b want 0", short_frame); end
      pix(1'b0, 1'b0);          // new pixel 0
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL abandon_early got %0b want 0", trigger_out); end
      pix(1'b0, 1'b0);          // new pixel 1 fires
      exp_frames++;
      compared++; if (trigger_out !== 1'b1) begin mismatched++; $display("FAIL abandon_fire got %0b want 1", trigger_out); end
      pix(1'b1, 1'b0);
      sop(4'h0, 1'b0, 16'd3);
      pix(1'b0, 1'b0);
      pix(1'b0, 1'b0);
      input_rst = 1'b1;         // asynchronous, mid-cycle
      #2;
      exp_frames = 0; exp_missed = 0;
      compared++; if (trigger_out !== 1'b0 || frame_count !== 16'd0 || missed_count !== 8'd0 || short_frame !== 1'b0) begin
         mismatched++; $display("FAIL async_reset got trig=%0b fc=%0d mc=%0d sf=%0b want all 0", trigger_out, frame_count, missed_count, short_frame);
      end
      @(posedge input_clock); #1;
      input_rst = 1'b0;
      for (int i = 2; i < 6; i++) pix(1'b0, 1'b0);
      pix(1'b1, 1'b0);
      compared++; if (trigger_out !== 1'b0 || short_frame !== 1'b0) begin mismatched++; $display("FAIL tail_ignored got trig=%0b sf=%0b want 0 0", trigger_out, short_frame); end
   endtask

   task automatic test_enable_off();
      enable = 1'b0;
      sop(4'h0, 1'b0, 16'd1);
      for (int i = 0; i < 3; i++) pix(1'b0, 1'b0);
      pix(1'b1, 1'b0);
      compared++; if (trigger_out !== 1'b0) begin mismatched++; $display("FAIL disabled_trigger got %0b want 0", trigger_out); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL disabled_count got %0d want %0d", frame_count, fc_exp()); end
      compared++; if (short_frame !== 1'b0) begin mismatched++; $display("FAIL disabled_short got %0b want 0", short_frame); end
      enable = 1'b1;
   endtask

   task automatic test_missed_saturation();
      for (int n = 1; n <= 300; n++) begin
         sop(4'h0, 1'b0, 16'd0);
         pix(1'b1, 1'b0);       // fire on pixel 0, never acked
         exp_frames++;
         if (n > 1 && exp_missed < 255) exp_missed++;
         if (n == 255) begin
            compared++; if (missed_count !== mc_exp()) begin mismatched++; $display("FAIL missed_254 got %0d want %0d", missed_count, mc_exp()); end
         end
      end
      compared++; if (missed_count !== mc_exp()) begin mismatched++; $display("FAIL missed_saturate got %0d want %0d", missed_count, mc_exp()); end
      compared++; if (frame_count !== fc_exp()) begin mismatched++; $display("FAIL count_300 got %0d want %0d", frame_count, fc_exp()); end
      compared++; if (trigger_out !== 1'b1) begin mismatched++; $display("FAIL sat_trigger got %0b want 1", trigger_out); end
   endtask

   initial begin
      test_reset();
      test_video_offset();
      test_ctrl_then_video();
      test_missed_and_same_cycle_ack();
      test_short_frame();
      test_sop_abandon_and_reset();
      test_enable_off();
      test_missed_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
